// File: rtl/inverse_cipher.sv
// inverse_cipher: fully pipelined AES-128 decryption, one block per clock, per-block key.
// Build macro INV_CIPHER_OUT_GATE_EN forces `out` to zero whenever valid_out is low.
module inverse_cipher #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [0:127] in,
    input  logic [0:127] key,
    output logic [0:127] out,
    output logic         valid_out
);

    localparam int KW = 32 * Nk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] a;
        a = gf_inv(b);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] rc;
        rc = 8'h01;
        for (int j = 1; j < 10; j++) begin
            if (j < n) rc = xtime(rc);
        end
        return rc;
    endfunction

    function automatic logic [127:0] last_round_key(input logic [127:0] k);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        for (int r = 1; r <= Nr; r++) begin
            w0 = w0 ^ sub_rot_word(w3) ^ {rcon(r), 24'h0};
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
        end
        return {w0, w1, w2, w3};
    endfunction

    // Steps the schedule back from words 4i+4..4i+7 to 4i..4i+3
    function automatic logic [127:0] prev_round_key(input logic [127:0] k, input int i);
        logic [31:0] w4, w5, w6, w7;
        {w4, w5, w6, w7} = k;
        w7 = w7 ^ w6;
        w6 = w6 ^ w5;
        w5 = w5 ^ w4;
        w4 = w4 ^ sub_rot_word(w7) ^ {rcon(i + 1), 24'h0};
        return {w4, w5, w6, w7};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic mix);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0] a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        t = t ^ rk;
        m = t;
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-8*(4*c)   -: 8];
                a1 = t[127-8*(4*c+1) -: 8];
                a2 = t[127-8*(4*c+2) -: 8];
                a3 = t[127-8*(4*c+3) -: 8];
                m[127-8*(4*c)   -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
                m[127-8*(4*c+1) -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
                m[127-8*(4*c+2) -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
                m[127-8*(4*c+3) -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
            end
        end
        return m;
    endfunction

    logic [127:0]  in_w;
    logic [127:0]  key_w;
    logic [127:0]  last_rk;
    logic [127:0]  state_d [0:Nr];
    logic [127:0]  state_q [0:Nr];
    logic [KW-1:0] rkey_d  [0:Nr-1];
    logic [KW-1:0] rkey_q  [0:Nr-1];
    logic [KW-1:0] rk_c    [1:Nr];
    logic [0:Nr]   vld_d;
    logic [0:Nr]   vld_q;

    assign in_w    = in;
    assign key_w   = key;
    assign last_rk = last_round_key(key_w);

    // Stage 0 whitens with the last round key; stage r undoes round Nr-r
    always_comb begin
        state_d[0] = in_w ^ last_rk;
        rkey_d[0]  = last_rk;
        vld_d[0]   = valid_in;
        for (int r = 1; r <= Nr; r++) begin
            rk_c[r]    = prev_round_key(rkey_q[r-1], Nr - r);
            state_d[r] = inv_round(state_q[r-1], rk_c[r], r != Nr);
            vld_d[r]   = vld_q[r-1];
        end
        for (int r = 1; r < Nr; r++) begin
            rkey_d[r] = rk_c[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= Nr; r++) state_q[r] <= '0;
            for (int r = 0; r < Nr; r++) rkey_q[r] <= '0;
            vld_q <= '0;
        end else begin
            state_q <= state_d;
            rkey_q  <= rkey_d;
            vld_q   <= vld_d;
        end
    end

    assign valid_out = vld_q[Nr];
`ifdef INV_CIPHER_OUT_GATE_EN
    assign out = vld_q[Nr] ? state_q[Nr] : 128'h0;
`else
    assign out = state_q[Nr];
`endif

endmodule

// File: tb/tb_inverse_cipher.sv
// Self-checking bench for inverse_cipher: FIPS vector table, bubbles, mid-flight reset,
// and random blocks encrypted by a forward AES model and expected back as plaintext.
module tb_inverse_cipher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic [0:127] in_i = '0;
    logic [0:127] key_i = '0;
    logic [0:127] out_o;
    logic         valid_out;

    inverse_cipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .in        (in_i),
        .key       (key_i),
        .out       (out_o),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int           due;
        logic [127:0] pt;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vt [5];

    logic [7:0] sbox_t [256];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward AES-128 (FIPS-197 Cipher) used to produce ciphertext for random plaintext
    function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] s, n;
        logic [7:0]   a [4];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        s = p ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            n = '0;
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    n[127-8*(4*c+rw) -: 8] = sbox_t[s[127-8*(4*((c+rw)%4)+rw) -: 8]];
            s = n;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = n[127-8*(4*c+j) -: 8];
                    for (int j = 0; j < 4; j++)
                        s[127-8*(4*c+j) -: 8] = xt(a[j]) ^ xt(a[(j+1)%4]) ^ a[(j+1)%4]
                                                ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] p);
        valid_in = v;
        key_i    = k;
        in_i     = c;
        if (v) sb.push_back('{due: cyc + 11, pt: p});
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, rnd128(), rnd128(), '0);
    endtask

    // Output checker: a block is expected exactly at its due cycle, nothing in between
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("valid_out_on_block", {127'h0, valid_out}, 128'h1);
                chk("plaintext", out_o, sb[0].pt);
                void'(sb.pop_front());
            end else begin
                chk("valid_out_in_bubble", {127'h0, valid_out}, 128'h0);
`ifdef INV_CIPHER_OUT_GATE_EN
                chk("out_gated_in_bubble", out_o, 128'h0);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p, q, x;
        logic [127:0] k, pt;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;

        vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff};
        vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0a940bb5416ef045f1c39458c653ea5a,
                  128'h000102030405060708090a0b0c0d0e0f};
        vt[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h20a9f992b44c5be8041ffcdc6cae996a,
                  128'h0f0e0d0c0b0a09080706050403020100};
        vt[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hb7ea90af536c82a8c8df97106b978f5a,
                  128'h00000101030307070f0f1f1f3f3f7f7f};
        vt[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734};

        // Reset state
        tick();
        tick();
        chk("reset_out", out_o, 128'h0);
        chk("reset_valid_out", {127'h0, valid_out}, 128'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Reference model against the known-answer table
        for (int i = 0; i < 5; i++) chk($sformatf("model_vec%0d", i), encrypt(vt[i].key, vt[i].pt), vt[i].ct);

        // Single isolated blocks: exact 11-cycle latency
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, vt[i].key, vt[i].ct, vt[i].pt);
            idle(13);
        end

        // Back-to-back same key, then alternating keys
        for (int i = 1; i <= 3; i++) issue(1'b1, vt[i].key, vt[i].ct, vt[i].pt);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, vt[i].key, vt[i].ct, vt[i].pt);
            issue(1'b1, vt[4].key, vt[4].ct, vt[4].pt);
        end
        idle(13);

        // Bubble pattern 1,0,1
        issue(1'b1, vt[1].key, vt[1].ct, vt[1].pt);
        issue(1'b0, rnd128(), rnd128(), '0);
        issue(1'b1, vt[2].key, vt[2].ct, vt[2].pt);
        idle(13);

        // Reset while five blocks are in flight
        for (int i = 0; i < 5; i++) issue(1'b1, vt[i].key, vt[i].ct, vt[i].pt);
        valid_in = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_out", out_o, 128'h0);
        chk("midreset_valid_out", {127'h0, valid_out}, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(15);
        issue(1'b1, vt[0].key, vt[0].ct, vt[0].pt);
        issue(1'b1, vt[4].key, vt[4].ct, vt[4].pt);
        idle(13);

        // Random keys and plaintexts, back-to-back
        for (int i = 0; i < 1000; i++) begin
            k  = rnd128();
            pt = rnd128();
            issue(1'b1, k, encrypt(k, pt), pt);
        end
        // Random blocks with random gaps
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                k  = rnd128();
                pt = rnd128();
                issue(1'b1, k, encrypt(k, pt), pt);
            end else begin
                issue(1'b0, rnd128(), rnd128(), '0);
            end
        end
        idle(15);
        chk("all_blocks_delivered", 128'(sb.size()), 128'h0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
